// File: rtl/an_residue_barrett.sv
// Three-stage Barrett residue generator for the AN-code datapath: emits each
// codeword with its residue mod A, flags non-zero residues and counts them.
module an_residue_barrett #(
    parameter int A  = 19,
    parameter int N  = 9,
    parameter int R  = 5,
    parameter int K  = 18,
    parameter int MU = 13797,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_codeword,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_codeword,
    output logic [R-1:0]  out_residue,
    output logic          out_err,
    output logic [CW-1:0] err_count,
    input  logic          err_clr
);

    localparam int MW = $clog2(MU + 1);
    localparam int PW = N + MW;
    localparam int RW = R + 2;

    localparam logic [PW-1:0] MU_P    = PW'(MU);
    localparam logic [N-1:0]  A_N     = N'(A);
    localparam logic [RW-1:0] A1      = RW'(A);
    localparam logic [RW-1:0] A2      = RW'(2 * A);
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic          en;
    logic          s1_valid;
    logic [N-1:0]  s1_x;
    logic [PW-1:0] s1_p;
    logic          s2_valid;
    logic [N-1:0]  s2_x;
    logic [RW-1:0] s2_r2;
    logic [PW-1:0] q_wide;
    logic [N-1:0]  qa;
    logic [RW-1:0] r2_d;
    logic [RW-1:0] residue_d;

    // One enable for every stage: the whole pipe freezes while the output is held.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // NOTE: sequential state uses non-blocking assignments so every stage samples
    // the pre-edge value of its predecessor.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_x     <= '0;
            s1_p     <= '0;
        end else if (en) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_x <= in_codeword;
                s1_p <= PW'(in_codeword) * MU_P;
            end
        end
    end

    // q underestimates the true quotient by at most 2, so r2 stays below 3A and
    // the low R+2 bits of x - q*A are exact.
    always_comb begin
        q_wide = s1_p >> K;
        qa     = N'(q_wide) * A_N;
        r2_d   = RW'(s1_x - qa);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_x     <= '0;
            s2_r2    <= '0;
        end else if (en) begin
            s2_valid <= s1_valid;
            s2_x     <= s1_x;
            s2_r2    <= r2_d;
        end
    end

    // NOTE: the default assignment first keeps this combinational block latch-free.
    always_comb begin
        residue_d = s2_r2;
        if (s2_r2 >= A2) begin
            residue_d = s2_r2 - A2;
        end else if (s2_r2 >= A1) begin
            residue_d = s2_r2 - A1;
        end
    end

    // NOTE: output data registers are reset as well, since the decoder sees
    // defined zero values on out_* while the pipe is empty after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_codeword <= '0;
            out_residue  <= '0;
            out_err      <= 1'b0;
        end else if (en) begin
            out_valid    <= s2_valid;
            out_codeword <= s2_x;
            out_residue  <= R'(residue_d);
            out_err      <= (residue_d != '0);
        end
    end

    // Counts only real transfers, so a held erroneous word is never counted twice.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= '0;
        end else if (err_clr) begin
            err_count <= '0;
        end else if (out_valid && out_ready && out_err && (err_count != CNT_MAX)) begin
            err_count <= err_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_an_residue_barrett.sv
// Self-checking bench for an_residue_barrett: directed scenarios plus random
// handshake traffic, scored against a transaction-level residue model.
module tb_an_residue_barrett;

    localparam int A      = 19;
    localparam int LAT    = 3;
    localparam int CNTMAX = 65535;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [8:0] in_codeword;
    logic       out_valid;
    logic       out_ready;
    logic [8:0] out_codeword;
    logic [4:0] out_residue;
    logic       out_err;
    logic [15:0] err_count;
    logic       err_clr;

    an_residue_barrett dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_codeword (in_codeword),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_codeword(out_codeword),
        .out_residue (out_residue),
        .out_err     (out_err),
        .err_count   (err_count),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of accepted words with accept cycle and stall count.
    typedef struct {
        int cw;
        int t;
        int s;
    } exp_t;

    exp_t exp_q[$];
    int   log_cw[$];
    int   log_res[$];
    int   log_err[$];
    int   model_cnt = 0;
    int   n_in      = 0;
    int   cyc       = 0;
    int   stalls    = 0;
    logic prev_stall = 1'b0;
    logic [8:0] held_cw;
    logic [4:0] held_res;
    logic       held_err;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            model_cnt  = 0;
            prev_stall = 1'b0;
        end else begin
            check("in_ready", in_ready, !out_valid || out_ready);
            check("err_count", err_count, model_cnt);
            if (prev_stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_codeword", out_codeword, held_cw);
                check("hold_residue", out_residue, held_res);
                check("hold_err", out_err, held_err);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_output", 1, 0);
                end else begin
                    exp_t e;
                    int   res;
                    e   = exp_q.pop_front();
                    res = e.cw % A;
                    check("codeword", out_codeword, e.cw);
                    check("residue", out_residue, res);
                    check("err_flag", out_err, res != 0);
                    check("latency", cyc - e.t, LAT + stalls - e.s);
                    log_cw.push_back(int'(out_codeword));
                    log_res.push_back(int'(out_residue));
                    log_err.push_back(int'(out_err));
                    if (!err_clr && res != 0 && model_cnt != CNTMAX) model_cnt++;
                end
            end
            if (err_clr) model_cnt = 0;
            if (in_valid && in_ready) begin
                exp_q.push_back('{cw: int'(in_codeword), t: cyc, s: stalls});
                n_in++;
            end
            prev_stall = out_valid && !out_ready;
            if (prev_stall) stalls++;
            held_cw  = out_codeword;
            held_res = out_residue;
            held_err = out_err;
        end
        cyc++;
    end

    // Offers one word and returns just after the edge that accepted it.
    task automatic send(input logic [8:0] w);
        int   n = 0;
        logic ok;
        in_valid    = 1'b1;
        in_codeword = w;
        do begin
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 1000);
        in_valid = 1'b0;
        if (!ok) check("send_timeout", 0, 1);
    endtask

    task automatic drain();
        int n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_done", n < 200, 1);
    endtask

    task automatic clear_count();
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
    endtask

    task automatic clear_log();
        log_cw.delete();
        log_res.delete();
        log_err.delete();
    endtask

    int t1_cw[6]  = '{0, 18, 38, 39, 70, 511};
    int t1_res[6] = '{0, 18, 0, 1, 13, 17};
    int t1_err[6] = '{0, 1, 0, 1, 1, 1};
    int t3_cw[3]  = '{57, 58, 76};
    int t3_res[3] = '{0, 1, 0};

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_codeword = '0;
        out_ready   = 1'b1;
        err_clr     = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_codeword", out_codeword, 0);
        check("rst_out_residue", out_residue, 0);
        check("rst_out_err", out_err, 0);
        check("rst_err_count", err_count, 0);
        check("rst_in_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed stream with literal expectations.
        clear_log();
        foreach (t1_cw[i]) send(9'(t1_cw[i]));
        drain();
        check("t1_count", log_res.size(), 6);
        for (int i = 0; i < 6 && i < log_res.size(); i++) begin
            check("t1_codeword", log_cw[i], t1_cw[i]);
            check("t1_residue", log_res[i], t1_res[i]);
            check("t1_err", log_err[i], t1_err[i]);
        end
        check("t1_err_count", err_count, 4);

        // Exhaustive sweep.
        clear_log();
        for (int w = 0; w < 512; w++) send(9'(w));
        drain();
        check("sweep_count", log_res.size(), 512);
        for (int i = 0; i < log_res.size(); i++) begin
            check("sweep_lt_a", log_res[i] < A, 1);
            check("sweep_order", log_cw[i], i);
        end

        // Stall with three words in flight.
        clear_count();
        clear_log();
        out_ready = 1'b0;
        foreach (t3_cw[i]) send(9'(t3_cw[i]));
        for (int i = 0; i < 5; i++) begin
            check("stall_in_ready", in_ready, 0);
            check("stall_valid", out_valid, 1);
            check("stall_codeword", out_codeword, 57);
            @(posedge clk);
            #1;
        end
        drain();
        check("t3_count", log_res.size(), 3);
        for (int i = 0; i < 3 && i < log_res.size(); i++) begin
            check("t3_codeword", log_cw[i], t3_cw[i]);
            check("t3_residue", log_res[i], t3_res[i]);
        end
        check("t3_err_count", err_count, 1);

        // Random handshake traffic.
        begin
            int n0 = n_in;
            int c  = 0;
            while (n_in - n0 < 10000 && c < 40000) begin
                in_valid    = ($urandom % 8) != 0;
                in_codeword = 9'($urandom_range(0, 511));
                out_ready   = ($urandom % 8) != 0;
                err_clr     = ($urandom % 512) == 0;
                @(posedge clk);
                #1;
                c++;
            end
            err_clr = 1'b0;
            check("random_words", n_in - n0 >= 10000, 1);
        end
        drain();

        // Asynchronous reset with a full, stalled pipe.
        send(9'd20);
        send(9'd21);
        out_ready = 1'b0;
        send(9'd22);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_err_count", err_count, 0);
        check("arst_residue", out_residue, 0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        begin
            int n;
            send(9'd100);
            n = 1;
            while (!out_valid && n < 10) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("arst_latency", n, LAT);
            check("arst_residue_after", out_residue, 100 % A);
        end
        drain();

        // Counter saturation and clear priority.
        clear_count();
        in_valid    = 1'b1;
        in_codeword = 9'd1;
        out_ready   = 1'b1;
        repeat (CNTMAX) @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain();
        check("sat_reach", err_count, CNTMAX);
        send(9'd1);
        drain();
        check("sat_hold", err_count, CNTMAX);
        begin
            int n = 0;
            send(9'd2);
            while (!out_valid && n < 10) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("clr_wait", out_valid, 1);
            err_clr = 1'b1;
            @(posedge clk);
            #1;
            err_clr = 1'b0;
            check("clr_priority", err_count, 0);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/an_residue_barrett.md
Name: an_residue_barrett

Overview:
- Pipelined residue generator for the AN-code datapath. Computes residue = codeword mod A using Barrett reduction.
- Sits directly upstream of the AN decoder. Delivers the codeword and its residue together, time-aligned, so the decoder can look up the error correction.
- Also flags non-zero residues (detected errors) and keeps a saturating count of them for status readout.

Parameters:
- A, 19, AN-code multiplier (odd, 3 ≤ A < 2^R).
- N, 9, codeword width.
- R, 5, residue width, ceil(log2 A).
- K, 18, Barrett shift, 2*N.
- MU, 13797, Barrett constant floor(2^K / A).
- CW, 16, error counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  input codeword valid.
- in_ready  out  1  block can accept input this cycle.
- in_codeword  in  N  received codeword.
- out_valid  out  1  out_codeword/out_residue valid.
- out_ready  in  1  decoder accepts output.
- out_codeword  out  N  codeword, aligned with its residue.
- out_residue  out  R  in_codeword mod A.
- out_err  out  1  out_residue != 0.
- err_count  out  CW  saturating count of accepted outputs with out_err=1.
- err_clr  in  1  synchronous clear of err_count.

Behaviour:
- Reset (async, rst=1): all stage valids 0, out_valid=0, out_codeword=0, out_residue=0, out_err=0, err_count=0. in_ready=1 while rst is low and the pipe is empty.
- Reset mid-operation discards all in-flight data. No output is produced for them.
- Pipeline has 3 register stages, all gated by a common enable en = !out_valid || out_ready.
  - in_ready = en, purely combinational from out_valid/out_ready.
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
- S1: register x = in_codeword and p = x*MU (N+14 bits, unsigned).
- S2: q = p >> K; r2 = x − q*A, computed at width R+2. r2 is guaranteed < 3A.
- S3: up to two conditional subtractions of A.
  - If r2 ≥ 2A: subtract 2A; else if r2 ≥ A: subtract A.
  - Register the result as out_residue (< A), along with out_codeword = x and out_err = (residue != 0).
- All arithmetic is unsigned. Intermediate widths must not truncate for any x in [0, 2^N − 1].
- Latency: a codeword accepted in cycle t appears with out_valid=1 in cycle t+3 when there are no stalls. Throughput is 1 per cycle.
- Valid bits propagate with their stage. Bubbles (in_valid=0) travel as valid=0 stages.
- Stall (out_valid=1, out_ready=0):
  - All stages hold.
  - in_ready=0.
  - out_* stay stable until the transfer.
- Error counter:
  - Increments by 1 on each output transfer with out_err=1.
  - Saturates at 2^CW − 1; no wrap.
  - err_clr=1 forces 0 on the next edge and takes priority over a simultaneous increment.
  - Increments only on actual transfers; held outputs are never counted twice.
- in_codeword is sampled only on an input transfer. Its value is ignored otherwise.

Test Plan:
- Reset then stream in_codeword 0, 18, 38, 39, 70, 511 with out_ready=1 → outputs 3 cycles later, one per cycle: residues 0, 18, 0, 1, 13, 17. Codewords match; out_err = 0, 1, 0, 1, 1, 1; err_count=4.
- Exhaustive sweep of all 512 codewords → every out_residue equals codeword mod 19 and is < 19. No codeword is lost or duplicated.
- Drive out_ready=0 for 5 cycles with 3 words in flight (57, 58, 76) → in_ready=0 and outputs stable for the whole stall. Words then drain in order with residues 0, 1, 0; err_count increments by exactly 1.
- Random in_valid/out_ready toggling over 10k words → the scoreboard sees in-order, exact residues, and err_count equals the count of non-zero residues transferred.
- Assert rst for 1 cycle with a full pipe → out_valid=0 and err_count=0 immediately, without waiting for a clock edge. The next input emerges 3 cycles after acceptance.
- Preload err_count to 2^16 − 1 via repeated erroneous words, then send another erroneous word → count stays 65535. Assert err_clr together with an erroneous transfer → count becomes 0.
